hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised hazard unit for the in-order integer pipeline, sitting beside ID.
- Holds a shift-register scoreboard of in-flight producers: destination register, write enable, and the stage at which each result becomes forwardable.
- From that scoreboard it generates per-operand forwarding selects and a data-stall for the ID stage.
- Replaces fixed per-stage compare chains with a DEPTH-deep, NSRC-operand generalisation that supports per-stage flush and a global pipeline-hold input.

Parameters:
- REG_W, 5, register index width.
- DEPTH, 4, number of tracked stages after ID (index 0 = EX, 1 = MEM1, 2 = MEM2, 3 = WB).
- NSRC, 2, number of source operands checked per ID instruction.
- SEL_W, $clog2(DEPTH+1), forwarding-select width.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_src  in  NSRC*REG_W  source register indices, operand j at [j*REG_W +: REG_W]
- id_src_used  in  NSRC  operand j is actually read
- id_rd  in  REG_W  destination register
- id_rfwr  in  1  instruction writes the register file
- id_ready_stg  in  SEL_W  stage index at which the result is forwardable (ALU 0, load 2, mfc0 1)
- pipe_en  in  1  global advance; 0 = whole pipe held (cache miss, div busy)
- flush_mask  in  DEPTH  bit i kills the stage-i entry this cycle
- fwd_sel  out  NSRC*SEL_W  per operand: 0 = register file, k = forward from stage k-1
- data_stall  out  1  ID must not issue this cycle
- issue  out  1  ID instruction enters stage 0 on this edge
- stall_cycles  out  32  only with HZ_PERF_EN

Behaviour:
- Entry i holds {valid, rd, ready_stg}. On reset, all valid bits clear; rd and ready_stg reset to 0; outputs take their combinational values from the cleared scoreboard (fwd_sel = 0, data_stall = 0).
- Match for operand j at stage i: entry[i].valid & id_src_used[j] & id_src[j] != 0 & entry[i].rd == id_src[j]. Register 0 never matches.
- Nearest match wins (lowest i).
  - If the winner has ready_stg <= i: fwd_sel[j] = i+1, no stall from operand j.
  - Otherwise operand j stalls and fwd_sel[j] = 0.
  - No match: fwd_sel[j] = 0.
- data_stall = id_valid & (any operand stalls).
- issue = id_valid & ~data_stall & pipe_en.
- Combinational outputs: fwd_sel and data_stall are pure functions of the current scoreboard and ID inputs (zero latency).
- Shift on a clk edge with pipe_en = 1:
  - entry[i] <= entry[i-1] for i >= 1; entry[DEPTH-1] retires.
  - entry[0] <= issue ? {id_rfwr, id_rd, id_ready_stg} : bubble (valid = 0).
  - An entry with id_rfwr = 0 is stored invalid.
- pipe_en = 0: all entries hold. issue = 0 (ID holds externally).
- flush_mask[i] = 1: that entry is invalidated this edge.
  - With pipe_en = 1, the invalidated entry moves to i+1 as a bubble.
  - flush_mask[0] together with issue: the new entry is still inserted. ID flush is the caller's job via id_valid.
- Simultaneous flush and stall: flush wins for the flushed entries; ID stall is re-evaluated next cycle against the cleaned scoreboard.
- ready_stg >= DEPTH is illegal. Such an entry never forwards and stalls any consumer until it retires.
- Async reset mid-operation: the scoreboard clears immediately; no stale forward after resetn rises.

Optional Feature:
- Macro HZ_PERF_EN.
- Defined: stall_cycles is a 32-bit saturating counter.
  - Increments on each cycle with data_stall = 1 and pipe_en = 1.
  - Reset 0 asynchronously; holds at 32'hFFFF_FFFF.
- Undefined: stall_cycles is tied to 0 and no counter flops exist.

Decomposition:
- Package hz_pkg:
  - scoreboard entry typedef {valid, rd, ready_stg}.
  - FWD_RF = 0 constant.
  - Stage index constants STG_EX = 0, STG_MEM1 = 1, STG_MEM2 = 2, STG_WB = 3.
- Sub-module hz_operand_match, instantiated NSRC times:
  - Inputs: one source index and the DEPTH entries.
  - Outputs: fwd_sel and an operand stall via priority search.

Test Plan:
- ALU producer r5 (ready_stg 0) issued, next instruction reads r5 as operand 0 → fwd_sel[0] = 1, data_stall = 0; one cycle later with a bubble between → fwd_sel[0] = 2.
- Load r7 (ready_stg 2) followed by a consumer of r7 → data_stall = 1 for 2 cycles (load in EX, then MEM1); at MEM2 fwd_sel = 3, issue = 1.
- r9 written in stage 0 and stage 2, consumer reads r9 on both operands → both fwd_sel = 1 (nearest wins).
- Consumer reads r0 while r0 is "written" in stage 0 → fwd_sel = 0, no stall.
- pipe_en = 0 for 3 cycles with load r4 in EX → scoreboard frozen, data_stall stays 1, issue = 0; after release, normal progression resumes.
- flush_mask = 4'b0011 with load r3 in EX and consumer in ID → next cycle data_stall = 0, fwd_sel = 0. With HZ_PERF_EN, stall_cycles counts exactly the stalled advancing cycles across the run.

Source files
------------

// File: rtl/hz_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hz_pkg
// Description : Shared types and constants for the ID-stage hazard
//               scoreboard. Stage indices count pipeline stages after ID.
// Revision    : 1.0 - initial release
// ============================================================================
package hz_pkg;

    // Default pipeline geometry
    localparam int HZ_REG_W = 5;
    localparam int HZ_DEPTH = 4;
    localparam int HZ_SEL_W = $clog2(HZ_DEPTH + 1);

    // Forwarding select value meaning "read the register file"
    localparam int FWD_RF = 0;

    // Stage indices of the tracked stages after ID
    localparam int STG_EX   = 0;
    localparam int STG_MEM1 = 1;
    localparam int STG_MEM2 = 2;
    localparam int STG_WB   = 3;

    // Layout of one scoreboard entry for the default geometry
    typedef struct packed {
        logic                valid;
        logic [HZ_REG_W-1:0] rd;
        logic [HZ_SEL_W-1:0] ready_stg;
    } hz_entry_t;

    // Forwarding select code for a producer sitting in stage 'stg'
    function automatic int hz_fwd_code(input int stg);
        return stg + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hz_operand_match.sv
`default_nettype none
// ============================================================================
// Module      : hz_operand_match
// Description : Priority search of the scoreboard for one source operand.
//               The nearest (lowest-index) valid producer of the operand's
//               register decides the result: forward from it if its result is
//               already forwardable at its current stage, otherwise stall.
// Ports       : i_src        - source register index
//               i_src_used   - operand is actually read
//               i_ent_valid  - per-stage valid bits
//               i_ent_rd     - per-stage destination, stage i at [i*REG_W +: REG_W]
//               i_ent_rdy    - per-stage ready stage, stage i at [i*SEL_W +: SEL_W]
//               o_fwd_sel    - 0 = register file, k = forward from stage k-1
//               o_stall      - operand cannot be supplied this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module hz_operand_match
    import hz_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int DEPTH = 4,
    parameter int SEL_W = $clog2(DEPTH + 1)
) (
    input  logic [REG_W-1:0]       i_src,
    input  logic                   i_src_used,
    input  logic [DEPTH-1:0]       i_ent_valid,
    input  logic [DEPTH*REG_W-1:0] i_ent_rd,
    input  logic [DEPTH*SEL_W-1:0] i_ent_rdy,
    output logic [SEL_W-1:0]       o_fwd_sel,
    output logic                   o_stall
);

    logic [SEL_W-1:0] w_fwd_sel;
    logic             w_stall;

    // Scan from the oldest stage towards EX so the nearest match is the
    // last one written and therefore wins. A ready stage at or beyond DEPTH
    // can never satisfy ready <= i, so such a producer always stalls.
    always_comb begin
        w_fwd_sel = SEL_W'(FWD_RF);
        w_stall   = 1'b0;
        if (i_src_used && (i_src != '0)) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (i_ent_valid[i] && (i_ent_rd[i*REG_W +: REG_W] == i_src)) begin
                    if (int'(i_ent_rdy[i*SEL_W +: SEL_W]) <= i) begin
                        w_fwd_sel = SEL_W'(hz_fwd_code(i));
                        w_stall   = 1'b0;
                    end else begin
                        w_fwd_sel = SEL_W'(FWD_RF);
                        w_stall   = 1'b1;
                    end
                end
            end
        end
    end

    assign o_fwd_sel = w_fwd_sel;
    assign o_stall   = w_stall;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Hazard unit beside ID. Tracks in-flight producers in a
//               DEPTH-deep shift register and derives per-operand forwarding
//               selects, the ID data stall and the issue strobe.
// Ports       : clk, resetn (async, active low)
//               id_valid, id_src, id_src_used, id_rd, id_rfwr, id_ready_stg
//                            - instruction currently in ID
//               pipe_en      - global advance, 0 holds the whole pipe
//               flush_mask   - bit i kills the stage-i entry this edge
//               fwd_sel      - per-operand forwarding select
//               data_stall   - ID must not issue
//               issue        - ID instruction enters stage 0 on this edge
//               stall_cycles - saturating stall counter
// Config      : HZ_PERF_EN - when defined, stall_cycles counts cycles with
//               data_stall = 1 and pipe_en = 1; otherwise it is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hz_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int DEPTH = 4,
    parameter int NSRC  = 2,
    parameter int SEL_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  id_valid,
    input  logic [NSRC*REG_W-1:0] id_src,
    input  logic [NSRC-1:0]       id_src_used,
    input  logic [REG_W-1:0]      id_rd,
    input  logic                  id_rfwr,
    input  logic [SEL_W-1:0]      id_ready_stg,
    input  logic                  pipe_en,
    input  logic [DEPTH-1:0]      flush_mask,
    output logic [NSRC*SEL_W-1:0] fwd_sel,
    output logic                  data_stall,
    output logic                  issue,
    output logic [31:0]           stall_cycles
);

    // Scoreboard, stage i occupies element i
    logic [DEPTH-1:0]            r_valid;
    logic [DEPTH-1:0][REG_W-1:0] r_rd;
    logic [DEPTH-1:0][SEL_W-1:0] r_rdy;

    logic [NSRC-1:0]       w_op_stall;
    logic [NSRC*SEL_W-1:0] w_fwd_sel;
    logic                  w_data_stall;
    logic                  w_issue;

    // ------------------------------------------------------------------
    // Per-operand priority search
    // ------------------------------------------------------------------
    generate
        for (genvar j = 0; j < NSRC; j++) begin : g_op
            hz_operand_match #(
                .REG_W (REG_W),
                .DEPTH (DEPTH),
                .SEL_W (SEL_W)
            ) u_match (
                .i_src       (id_src[j*REG_W +: REG_W]),
                .i_src_used  (id_src_used[j]),
                .i_ent_valid (r_valid),
                .i_ent_rd    (r_rd),
                .i_ent_rdy   (r_rdy),
                .o_fwd_sel   (w_fwd_sel[j*SEL_W +: SEL_W]),
                .o_stall     (w_op_stall[j])
            );
        end
    endgenerate

    assign w_data_stall = id_valid & (|w_op_stall);
    assign w_issue      = id_valid & ~w_data_stall & pipe_en;

    assign fwd_sel    = w_fwd_sel;
    assign data_stall = w_data_stall;
    assign issue      = w_issue;

    // ------------------------------------------------------------------
    // Scoreboard shift register. A flushed entry still advances but as a
    // bubble; the new stage-0 entry is inserted even when flush_mask[0]
    // is set, since killing the ID instruction is done via id_valid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= '0;
            r_rd    <= '0;
            r_rdy   <= '0;
        end else if (pipe_en) begin
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1] & ~flush_mask[i-1];
                r_rd[i]    <= r_rd[i-1];
                r_rdy[i]   <= r_rdy[i-1];
            end
            // Non-writing instructions occupy the slot as a bubble
            r_valid[0] <= w_issue & id_rfwr;
            r_rd[0]    <= id_rd;
            r_rdy[0]   <= id_ready_stg;
        end else begin
            r_valid <= r_valid & ~flush_mask;
        end
    end

    // ------------------------------------------------------------------
    // Optional stall statistics
    // ------------------------------------------------------------------
`ifdef HZ_PERF_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stall_cycles <= '0;
        end else if (w_data_stall && pipe_en && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed self-checking bench for hazard_scoreboard. A queue of
//               in-flight producers (front = EX) predicts every output on
//               every cycle; literal expectations pin the key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int REG_W = 5;
    localparam int DEPTH = 4;
    localparam int NSRC  = 2;
    localparam int SEL_W = 3;

    logic                  clk;
    logic                  resetn;
    logic                  id_valid;
    logic [NSRC*REG_W-1:0] id_src;
    logic [NSRC-1:0]       id_src_used;
    logic [REG_W-1:0]      id_rd;
    logic                  id_rfwr;
    logic [SEL_W-1:0]      id_ready_stg;
    logic                  pipe_en;
    logic [DEPTH-1:0]      flush_mask;
    logic [NSRC*SEL_W-1:0] fwd_sel;
    logic                  data_stall;
    logic                  issue;
    logic [31:0]           stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_scoreboard #(
        .REG_W (REG_W),
        .DEPTH (DEPTH),
        .NSRC  (NSRC),
        .SEL_W (SEL_W)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .id_valid     (id_valid),
        .id_src       (id_src),
        .id_src_used  (id_src_used),
        .id_rd        (id_rd),
        .id_rfwr      (id_rfwr),
        .id_ready_stg (id_ready_stg),
        .pipe_en      (pipe_en),
        .flush_mask   (flush_mask),
        .fwd_sel      (fwd_sel),
        .data_stall   (data_stall),
        .issue        (issue),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Model: instructions in flight, index = stage after ID
    // ------------------------------------------------------------------
    typedef struct {
        logic [REG_W-1:0] rd;
        bit               live;
        int               rdy;
    } prod_t;

    prod_t pipe_q[$];
    int    perf_cnt = 0;

    // Youngest in-flight writer of the register decides; it can forward
    // only once it has reached its ready stage.
    function automatic void model_eval(output logic [NSRC*SEL_W-1:0] f, output logic st);
        logic [REG_W-1:0] s;
        f  = '0;
        st = 1'b0;
        for (int j = 0; j < NSRC; j++) begin
            s = id_src[j*REG_W +: REG_W];
            if (id_src_used[j] && s != 0) begin
                for (int k = 0; k < pipe_q.size(); k++) begin
                    if (pipe_q[k].live && pipe_q[k].rd == s) begin
                        if (k >= pipe_q[k].rdy) f[j*SEL_W +: SEL_W] = SEL_W'(k + 1);
                        else st = 1'b1;
                        break;
                    end
                end
            end
        end
    endfunction

    // Advance the model with the inputs present at the clock edge
    task automatic model_step();
        logic [NSRC*SEL_W-1:0] f;
        logic                  st;
        logic                  iss;
        prod_t                 p;
        if (!resetn) begin
            pipe_q.delete();
            perf_cnt = 0;
        end else begin
            model_eval(f, st);
            iss = id_valid & ~st & pipe_en;
            for (int k = 0; k < pipe_q.size(); k++)
                if (flush_mask[k]) pipe_q[k].live = 0;
            if (pipe_en) begin
                if (id_valid && st) perf_cnt++;
                p.rd   = id_rd;
                p.live = iss & id_rfwr;
                p.rdy  = int'(id_ready_stg);
                pipe_q.push_front(p);
                if (pipe_q.size() > DEPTH) void'(pipe_q.pop_back());
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // ------------------------------------------------------------------
    // Per-cycle comparison against the model
    // ------------------------------------------------------------------
    initial begin
        logic [NSRC*SEL_W-1:0] ef;
        logic                  es;
        logic                  ed;
        logic                  ei;
        logic [31:0]           ep;
        forever begin
            @(negedge clk);
            model_eval(ef, es);
            ed = id_valid & es;
            ei = id_valid & ~ed & pipe_en;
            n_checks++;
            if (fwd_sel !== ef || data_stall !== ed || issue !== ei) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t: got fwd_sel=%h data_stall=%b issue=%b, expected fwd_sel=%h data_stall=%b issue=%b",
                         $time, fwd_sel, data_stall, issue, ef, ed, ei);
            end
`ifdef HZ_PERF_EN
            ep = 32'(perf_cnt);
`else
            ep = 32'd0;
`endif
            n_checks++;
            if (stall_cycles !== ep) begin
                n_fail++;
                $display("FAIL model_perf t=%0t: got stall_cycles=%0d, expected %0d", $time, stall_cycles, ep);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic set(input logic v, input logic [REG_W-1:0] s0, input logic [REG_W-1:0] s1,
                       input logic [1:0] used, input logic [REG_W-1:0] rd, input logic wr,
                       input logic [SEL_W-1:0] rdy, input logic pen, input logic [DEPTH-1:0] fm);
        id_valid     = v;
        id_src       = {s1, s0};
        id_src_used  = used;
        id_rd        = rd;
        id_rfwr      = wr;
        id_ready_stg = rdy;
        pipe_en      = pen;
        flush_mask   = fm;
    endtask

    // Literal expectation; f = {fwd_sel[1], fwd_sel[0]}
    task automatic lit(input string nm, input logic [NSRC*SEL_W-1:0] f, input logic s, input logic i);
        #1;
        n_checks++;
        if (fwd_sel !== f || data_stall !== s || issue !== i) begin
            n_fail++;
            $display("FAIL %s: got fwd_sel=%h data_stall=%b issue=%b, expected fwd_sel=%h data_stall=%b issue=%b",
                     nm, fwd_sel, data_stall, issue, f, s, i);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] exp_perf;
        resetn = 1'b0;
        set(0, 0, 0, 2'b00, 0, 0, 0, 1, 0);
        tick();
        tick();
        resetn = 1'b1;
        lit("reset_idle", 6'o00, 0, 0);
        set(1, 5, 0, 2'b01, 0, 0, 0, 1, 0);
        lit("reset_no_fwd", 6'o00, 0, 1);
        tick();

        // ALU producer r5, then consumers at distance 1 and 2
        set(1, 0, 0, 2'b00, 5, 1, 0, 1, 0);
        lit("alu_issue", 6'o00, 0, 1);
        tick();
        set(1, 5, 0, 2'b01, 0, 0, 0, 1, 0);
        lit("alu_fwd_ex", 6'o01, 0, 1);
        tick();
        lit("alu_fwd_mem1", 6'o02, 0, 1);
        tick();

        // Load r7 (ready in MEM2), consumer on operand 1
        set(1, 0, 0, 2'b00, 7, 1, 2, 1, 0);
        tick();
        set(1, 0, 7, 2'b10, 0, 0, 0, 1, 0);
        lit("load_stall_ex", 6'o00, 1, 0);
        tick();
        lit("load_stall_mem1", 6'o00, 1, 0);
        tick();
        lit("load_fwd_mem2", 6'o30, 0, 1);
        tick();

        // r9 written in stages 2 and 0, read on both operands
        set(1, 0, 0, 2'b00, 9, 1, 0, 1, 0);
        tick();
        set(0, 0, 0, 2'b00, 0, 0, 0, 1, 0);
        tick();
        set(1, 0, 0, 2'b00, 9, 1, 0, 1, 0);
        tick();
        set(1, 9, 9, 2'b11, 0, 0, 0, 1, 0);
        lit("nearest_wins", 6'o11, 0, 1);
        tick();

        // r0 never matches
        set(1, 0, 0, 2'b00, 0, 1, 0, 1, 0);
        tick();
        set(1, 0, 0, 2'b11, 0, 0, 0, 1, 0);
        lit("r0_never", 6'o00, 0, 1);
        tick();

        // Pipe hold with load r4 in EX
        set(1, 0, 0, 2'b00, 4, 1, 2, 1, 0);
        tick();
        set(1, 4, 0, 2'b01, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            lit("hold_frozen", 6'o00, 1, 0);
            tick();
        end
        pipe_en = 1'b1;
        lit("hold_release_ex", 6'o00, 1, 0);
        tick();
        lit("hold_release_mem1", 6'o00, 1, 0);
        tick();
        lit("hold_release_mem2", 6'o03, 0, 1);
        tick();

        // Flush of EX/MEM1 with load r3 in EX
        set(1, 0, 0, 2'b00, 3, 1, 2, 1, 0);
        tick();
        set(1, 3, 0, 2'b01, 0, 0, 0, 1, 4'b0011);
        lit("flush_cycle", 6'o00, 1, 0);
        tick();
        flush_mask = 4'b0000;
        lit("after_flush", 6'o00, 0, 1);
        tick();

        // Illegal ready stage stalls until the producer retires
        set(1, 0, 0, 2'b00, 6, 1, 4, 1, 0);
        tick();
        set(1, 6, 0, 2'b01, 0, 0, 0, 1, 0);
        for (int c = 0; c < DEPTH; c++) begin
            lit("illegal_rdy_stall", 6'o00, 1, 0);
            tick();
        end
        lit("illegal_rdy_retired", 6'o00, 0, 1);
        tick();

        // Flush while the pipe is held
        set(1, 0, 0, 2'b00, 8, 1, 2, 1, 0);
        tick();
        set(1, 8, 0, 2'b01, 0, 0, 0, 0, 4'b0001);
        lit("flush_hold", 6'o00, 1, 0);
        tick();
        set(1, 8, 0, 2'b01, 0, 0, 0, 1, 0);
        lit("flush_hold_clean", 6'o00, 0, 1);
        tick();

        // flush_mask[0] together with issue still inserts the new entry
        set(1, 0, 0, 2'b00, 10, 1, 0, 1, 4'b0001);
        lit("flush0_issue", 6'o00, 0, 1);
        tick();
        set(1, 10, 0, 2'b01, 0, 0, 0, 1, 0);
        lit("flush0_insert", 6'o01, 0, 1);
        tick();

        // Stalled advancing cycles so far: 2 + 2 + 1 + 4
`ifdef HZ_PERF_EN
        exp_perf = 32'd9;
`else
        exp_perf = 32'd0;
`endif
        n_checks++;
        if (stall_cycles !== exp_perf) begin
            n_fail++;
            $display("FAIL perf_total: got stall_cycles=%0d, expected %0d", stall_cycles, exp_perf);
        end

        // Asynchronous reset mid-operation
        set(1, 0, 0, 2'b00, 11, 1, 0, 1, 0);
        tick();
        set(1, 11, 0, 2'b01, 0, 0, 0, 1, 0);
        #2;
        resetn = 1'b0;
        pipe_q.delete();
        perf_cnt = 0;
        lit("async_reset", 6'o00, 0, 1);
        tick();
        resetn = 1'b1;
        lit("post_reset", 6'o00, 0, 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
